// File: rtl/reg_addr_seq_pkg.sv
// reg_addr_seq_pkg: shared mode codes, FSM states and default register indices
package reg_addr_seq_pkg;
  localparam logic [2:0] MODE_RN      = 3'd0;
  localparam logic [2:0] MODE_RD_PX   = 3'd1;
  localparam logic [2:0] MODE_PC      = 3'd2;
  localparam logic [2:0] MODE_LR      = 3'd3;
  localparam logic [2:0] MODE_LIST_UP = 3'd4;
  localparam logic [2:0] MODE_LIST_DN = 3'd5;
  localparam int DEF_PC_IDX = 15;
  localparam int DEF_LR_IDX = 14;
  typedef enum logic [1:0] {IDLE, SEQ, FIN} state_e;
endpackage

// File: rtl/reg_list_prienc.sv
// reg_list_prienc: lowest or highest set index of a register mask, plus any-set flag
module reg_list_prienc #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] mask,
  input  logic         high_first,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    any = |mask;
    if (high_first) begin
      for (int i = 0; i < N; i++) if (mask[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--) if (mask[i]) idx = W'(i);
    end
  end
endmodule

// File: rtl/reg_addr_sequencer.sv
// reg_addr_sequencer: emits register-file addresses one per accepted advance
// for single-register selections and ascending/descending register-list walks.
module reg_addr_sequencer import reg_addr_seq_pkg::*; #(
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int IRW    = 32,
  parameter int RN_LSB = 16,
  parameter int RD_LSB = 12,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int LR_IDX = DEF_LR_IDX
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     mode,
  input  logic [IRW-1:0] ir,
  input  logic [AW-1:0]  px,
  input  logic           advance,
  output logic [AW-1:0]  addr_out,
  output logic           addr_valid,
  output logic           busy,
  output logic           done,
  output logic [AW:0]    count,
  output logic           err
);
  state_e state_q, state_d;
  logic [NREGS-1:0] mask_q, mask_d, load_mask;
  logic [AW-1:0] addr_q, addr_d, rd_idx, single_idx;
  logic [AW:0] count_q, count_d;
  logic dir_q, dir_d, err_q, err_d, any, take, accept, rsvd, is_list;
  logic unused_ir;
  assign unused_ir = ^ir;
  assign take    = state_q == IDLE && start;
  assign accept  = state_q == SEQ && advance;
  assign rsvd    = mode > MODE_LIST_DN;
  assign is_list = mode == MODE_LIST_UP || mode == MODE_LIST_DN;
  assign rd_idx  = ir[RD_LSB+:AW] + px;
  assign single_idx = mode == MODE_RN ? ir[RN_LSB+:AW] : mode == MODE_RD_PX ? rd_idx :
                      mode == MODE_PC ? AW'(PC_IDX) : AW'(LR_IDX);
  assign load_mask = rsvd ? '0 : is_list ? ir[NREGS-1:0] : NREGS'(1) << single_idx;
  always_comb begin
    mask_d  = mask_q;
    dir_d   = dir_q;
    count_d = count_q;
    err_d   = err_q;
    if (take) begin
      mask_d  = load_mask;
      dir_d   = mode == MODE_LIST_DN;
      count_d = '0;
      err_d   = rsvd;
    end else if (accept) begin
      mask_d  = mask_q & ~(NREGS'(1) << addr_q);
      count_d = count_q + 1'b1;
    end
  end
  // The encoder looks at the next mask so the following address is ready with no bubble.
  reg_list_prienc #(.N(NREGS), .W(AW)) u_enc (
    .mask(mask_d), .high_first(dir_d), .idx(addr_d), .any(any)
  );
  always_comb begin
    state_d = state_q == FIN ? IDLE : state_q;
    if (take || accept) state_d = any ? SEQ : FIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
  assign addr_out   = addr_q;
  assign addr_valid = state_q == SEQ;
  assign busy       = state_q == SEQ;
  assign done       = state_q == FIN;
  assign count      = count_q;
  assign err        = err_q;
endmodule
